// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start in IDLE loads the operand; BIN_W iterations later bcd is updated and
// done pulses for one cycle. bcd only ever changes on that completion edge.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; bcd holds the last result
// CONV  | one correct-and-shift iteration per clock, counter counts up
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3,
   parameter int CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int         BCD_W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   // Refuse to elaborate if the largest operand cannot fit, or the counter cannot reach BIN_W-1.
   generate
      if (64'(10) ** DIGITS <= (64'(1) << BIN_W) - 64'(1)) begin : g_digits_check
         $error("bin2bcd_seq: DIGITS too small for BIN_W");
      end
      if ((64'(1) << CNT_W) <= 64'(BIN_W)) begin : g_cnt_check
         $error("bin2bcd_seq: CNT_W too small for BIN_W");
      end
   endgenerate

   typedef enum logic {IDLE, CONV} state_t;

   state_t                     state_q, state_d;
   logic [BIN_W-1:0]           shreg;
   logic [BCD_W-1:0]           scratch;
   logic [BCD_W-1:0]           scratch_adj;
   logic [BCD_W+BIN_W-1:0]     shifted;
   logic [CNT_W-1:0]           cnt;
   logic                       load;
   logic                       step;
   logic                       finish;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and iteration control.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            step = 1'b1;
            if (cnt == LAST_CNT) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Add 3 to every digit >= 5, then shift the digits and operand left as one word.
   always_comb begin
      scratch_adj = scratch;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
      shifted = {scratch_adj, shreg} << 1;
   end

   // Datapath: operand load, iteration, and result/done registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd     <= '0;
         done    <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= '0;
         end else if (step) begin
            shreg   <= shifted[BIN_W-1:0];
            scratch <= shifted[BCD_W+BIN_W-1:BIN_W];
            cnt     <= cnt + CNT_W'(1);
         end
         if (finish) bcd <= shifted[BCD_W+BIN_W-1:BIN_W];
      end
   end

   assign busy = (state_q == CONV);

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

   typedef struct {
      logic [11:0] exp;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [7:0]  bin_a = '0;
   logic [3:0]  bin_b = '0;
   logic        busy_a, done_a, busy_b, done_b;
   logic [11:0] bcd_a;
   logic [7:0]  bcd_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   bin2bcd_seq dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
      .busy(busy_a), .done(done_a), .bcd(bcd_a)
   );

   bin2bcd_seq #(.BIN_W(4), .DIGITS(2), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
      .busy(busy_b), .done(done_b), .bcd(bcd_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] to_bcd(input int v, input int nd);
      logic [11:0] r;
      int          x;
      r = '0;
      x = v;
      for (int k = 0; k < nd; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the default instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done_a) begin
            if (q_a.size() == 0) check("a_unexpected_done", 32'(done_a), 32'd0);
            else begin
               e = q_a.pop_front();
               check("a_bcd", 32'(bcd_a), 32'(e.exp));
               check("a_latency", 32'(cyc), 32'(e.due));
            end
         end else if (q_a.size() != 0 && cyc > q_a[0].due) begin
            check("a_done_on_time", 32'(done_a), 32'd1);
            void'(q_a.pop_front());
         end
      end
   end

   // Scoreboard for the 4-bit instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done_b) begin
            if (q_b.size() == 0) check("b_unexpected_done", 32'(done_b), 32'd0);
            else begin
               e = q_b.pop_front();
               check("b_bcd", 32'(bcd_b), 32'(e.exp));
               check("b_latency", 32'(cyc), 32'(e.due));
            end
         end else if (q_b.size() != 0 && cyc > q_b[0].due) begin
            check("b_done_on_time", 32'(done_b), 32'd1);
            void'(q_b.pop_front());
         end
      end
   end

   task automatic drain_a();
      for (int i = 0; i < 30 && q_a.size() != 0; i++) @(negedge clk);
      check("a_drain_timeout", 32'(q_a.size()), 32'd0);
   endtask

   task automatic conv_a(input int v);
      @(negedge clk);
      bin_a   = 8'(v);
      start_a = 1'b1;
      q_a.push_back('{exp: to_bcd(v, 3), due: cyc + 9});
      @(negedge clk);
      start_a = 1'b0;
      drain_a();
   endtask

   task automatic conv_b(input int v);
      @(negedge clk);
      bin_b   = 4'(v);
      start_b = 1'b1;
      q_b.push_back('{exp: to_bcd(v, 2), due: cyc + 5});
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 20 && q_b.size() != 0; i++) @(negedge clk);
      check("b_drain_timeout", 32'(q_b.size()), 32'd0);
   endtask

   initial begin
      int nb;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_bcd",  32'(bcd_a),  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // bin=0: busy for exactly 8 cycles, single done checked by scoreboard.
      bin_a   = 8'd0;
      start_a = 1'b1;
      q_a.push_back('{exp: 12'h000, due: cyc + 9});
      nb = 0;
      @(negedge clk); start_a = 1'b0; nb += int'(busy_a);
      repeat (13) begin @(negedge clk); nb += int'(busy_a); end
      check("zero_busy_cycles", 32'(nb), 32'd8);
      drain_a();

      conv_a(255);
      conv_a(99);
      conv_a(100);
      conv_a(9);
      repeat (5) @(negedge clk);
      check("bcd_holds", 32'(bcd_a), 32'h009);

      // start while busy is ignored.
      @(negedge clk);
      bin_a   = 8'd37;
      start_a = 1'b1;
      q_a.push_back('{exp: 12'h037, due: cyc + 9});
      nb = 0;
      @(negedge clk); start_a = 1'b0; nb += int'(busy_a);
      @(negedge clk); nb += int'(busy_a);
      @(negedge clk); bin_a = 8'd200; start_a = 1'b1; nb += int'(busy_a);
      @(negedge clk); start_a = 1'b0; nb += int'(busy_a);
      repeat (10) begin @(negedge clk); nb += int'(busy_a); end
      check("ignored_start_busy", 32'(nb), 32'd8);
      drain_a();

      // Back-to-back with start held high; second accepted in the done cycle.
      @(negedge clk);
      bin_a   = 8'd42;
      start_a = 1'b1;
      q_a.push_back('{exp: 12'h042, due: cyc + 9});
      q_a.push_back('{exp: 12'h213, due: cyc + 18});
      @(negedge clk);
      bin_a = 8'd213;
      repeat (9) @(negedge clk);
      start_a = 1'b0;
      drain_a();
      repeat (12) @(negedge clk);

      // Reset mid-conversion aborts with no done.
      @(negedge clk);
      bin_a   = 8'd128;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_done", 32'(done_a), 32'd0);
      check("abort_bcd",  32'(bcd_a),  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_result", 32'(bcd_a), 32'd0);
      conv_a(128);

      // Narrow instance sweep.
      for (int v = 0; v < 16; v++) conv_b(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts a BIN_W-bit unsigned value into DIGITS packed BCD digits, one bit per clock.
- Replaces per-digit combinational +6 correction where wide values or multi-digit displays are needed.
- Sits between datapath counters/registers and the seven-segment/display drivers; uses a start/busy/done handshake.

Parameters:
- BIN_W, 8: width of the binary input.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration fails via a generate-time check otherwise.
- CNT_W, 4: width of the iteration counter. Must satisfy 2^CNT_W > BIN_W.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only while idle.
- bin  input  BIN_W  unsigned binary operand; captured on the accepted start edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*DIGITS  packed result; digit k is at bits [4k+3:4k], digit 0 is the units digit.

Behaviour:
- Reset, applied asynchronously while rst=1:
  - state=IDLE; busy=0, done=0, bcd=0.
  - Shift register, scratch digits and counter are all cleared.
- IDLE:
  - If start=1 at edge E0: capture bin into the shift register, clear the scratch digits, set counter=0, set busy=1, go to CONV.
  - If start=0: remain in IDLE.
- CONV, one iteration per edge (E1..E_BIN_W):
  - For every scratch digit with value >= 5, add 3 (4-bit add, no carry out; the result is always <= 12).
  - Then shift {scratch digits, shift register} left by 1. The shift register MSB enters bit 0 of digit 0.
  - Increment the counter.
- Completion, on the edge where counter reaches BIN_W-1 before increment (edge E_BIN_W):
  - bcd <= the corrected-and-shifted scratch value.
  - done <= 1, busy <= 0, state returns to IDLE.
- Latency and throughput:
  - done is high during the cycle following E_BIN_W, i.e. exactly BIN_W cycles after the start edge.
  - done drops on the next edge.
- bcd holds its value until the next done. It is never partially updated; intermediate values stay internal.
- start while busy=1 is ignored: no queueing, bin is not re-sampled.
- start=1 during the done cycle: the state is IDLE, so it is accepted. Back-to-back throughput is one result per BIN_W+1 cycles.
- start held high continuously gives repeated conversions. Each conversion samples bin at its own acceptance edge.
- bin changes during CONV have no effect.
- rst asserted mid-conversion:
  - Aborts immediately; no done pulse.
  - bcd clears to 0.
  - First accepted start after rst deasserts begins a fresh conversion.
- Unused upper digits read 0.
- The maximum input 2^BIN_W-1 must convert without overflow. This is guaranteed by the DIGITS constraint.

Test Plan:
- Default params, bin=8'd0, start pulse:
  - busy=1 for 8 cycles.
  - Single-cycle done exactly 8 cycles after the start edge.
  - bcd=12'h000.
- Default params, bin=255 -> bcd=12'h255. bin=99 -> 12'h099. bin=100 -> 12'h100. bin=9 -> 12'h009. Covers digit-boundary and carry-into-next-digit cases.
- Start while busy:
  - Start with bin=37, then pulse start with bin=200 at cycle 3.
  - Only one done; bcd=12'h037; busy stays high with no extension.
- Back-to-back:
  - start held high with bin=42, then bin=213 applied after the first acceptance.
  - First done gives 12'h042; second start is accepted in the done cycle; second done gives 12'h213 nine cycles after the first.
- Reset mid-conversion:
  - Start with bin=128, assert rst asynchronously (between edges) at cycle 4.
  - busy, done and bcd go to 0 immediately; no done pulse follows.
  - After release, start with bin=128 yields 12'h128.
- Alternate instance BIN_W=4, DIGITS=2, CNT_W=3:
  - Sweep bin 0..15; each done occurs 4 cycles after start.
  - bcd equals the decimal value, e.g. 10 -> 8'h10, 15 -> 8'h15, 9 -> 8'h09.
